// File: rtl/float_pkg.sv
// Shared definitions for the float datapath: field widths, exponent limits,
// normalizer state encoding and the special packed result patterns.
package float_pkg;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = 26;
    localparam int WORK_W  = MANT_W + 1;   // mantissa plus ALU carry
    localparam int EW      = EXP_W + 2;    // signed working exponent
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, PACK} state_t;

    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
endpackage

// File: rtl/float_round.sv
// Round-to-nearest-even on a normalized working mantissa (guard m[1], sticky m[0]),
// renormalizing by one place when the increment carries into m[26].
module float_round
    import float_pkg::*;
(
    input  logic [WORK_W-1:0]    m_in,
    input  logic signed [EW-1:0] e_in,
    output logic [WORK_W-1:0]    m_out,
    output logic signed [EW-1:0] e_out
);
    logic              inc;
    logic [WORK_W-3:0] sum;
    logic [WORK_W-1:0] rounded;

    assign inc     = m_in[1] & (m_in[0] | m_in[2]);
    assign sum     = m_in[WORK_W-1:2] + {{(WORK_W-3){1'b0}}, inc};
    assign rounded = {sum, m_in[1:0]};

    always_comb begin
        m_out = rounded;
        e_out = e_in;
        if (rounded[WORK_W-1]) begin
            m_out = {1'b0, rounded[WORK_W-1:1]};
            e_out = e_in + EW'(1);
        end
    end
endmodule

// File: rtl/float_normalizer.sv
// Iterative post-ALU normalizer: one shift per cycle, RNE rounding, IEEE-754
// single packing, with overflow/underflow/zero flags and a start/done handshake.
module float_normalizer
    import float_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic              carry_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic              overflow,
    output logic              underflow,
    output logic              zero
);
    localparam logic signed [EW-1:0] E_MAX = EW'(EXP_MAX);

    state_t                state, state_nxt;
    logic [WORK_W-1:0]     m, m_nxt, m_rnd;
    logic signed [EW-1:0]  e, e_nxt, e_rnd, e_dec;
    logic                  sign, sign_nxt;
    logic [31:0]           result_nxt;
    logic                  busy_nxt, done_nxt, overflow_nxt, underflow_nxt, zero_nxt;

    float_round u_round (
        .m_in  (m),
        .e_in  (e),
        .m_out (m_rnd),
        .e_out (e_rnd)
    );

    assign e_dec = e - EW'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            m         <= '0;
            e         <= '0;
            sign      <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
        end else begin
            state     <= state_nxt;
            m         <= m_nxt;
            e         <= e_nxt;
            sign      <= sign_nxt;
            result    <= result_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
            zero      <= zero_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        m_nxt         = m;
        e_nxt         = e;
        sign_nxt      = sign;
        result_nxt    = result;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        overflow_nxt  = overflow;
        underflow_nxt = underflow;
        zero_nxt      = zero;

        unique case (state)
            IDLE: begin
                if (start) begin
                    m_nxt         = {carry_in, mant_in};
                    e_nxt         = {2'b00, exp_in};
                    sign_nxt      = sign_in;
                    busy_nxt      = 1'b1;
                    overflow_nxt  = 1'b0;
                    underflow_nxt = 1'b0;
                    zero_nxt      = 1'b0;
                    state_nxt     = NORM;
                end
            end
            NORM: begin
                if (m == '0) begin
                    zero_nxt  = 1'b1;
                    state_nxt = PACK;
                end else if (m[WORK_W-1]) begin
                    m_nxt     = {1'b0, m[WORK_W-1:2], m[1] | m[0]};
                    e_nxt     = e + EW'(1);
                    state_nxt = ROUND;
                end else if (m[MANT_W-1]) begin
                    state_nxt = ROUND;
                end else begin
                    m_nxt = {m[WORK_W-2:0], 1'b0};
                    e_nxt = e_dec;
                    // Exponent exhausted before the hidden bit arrived: flush.
                    if (e_dec[EW-1] || e_dec == '0) begin
                        underflow_nxt = 1'b1;
                        state_nxt     = PACK;
                    end
                end
            end
            ROUND: begin
                m_nxt = m_rnd;
                e_nxt = e_rnd;
                if (e_rnd >= E_MAX)
                    overflow_nxt = 1'b1;
                state_nxt = PACK;
            end
            PACK: begin
                if (zero || underflow)
                    result_nxt = sign ? NEG_ZERO : POS_ZERO;
                else if (overflow)
                    result_nxt = sign ? NEG_INF : POS_INF;
                else
                    result_nxt = {sign, e[EXP_W-1:0], m[MANT_W-2:2]};
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/float_normalizer.md
Name: float_normalizer

Overview:
- Post-ALU stage of the float datapath: consumes the 26-bit mantissa result plus carry from the mantissa ALU, together with the sign and the biased exponent.
- Normalizes iteratively, one bit per cycle; applies round-to-nearest-even; packs an IEEE-754 single-precision word.
- Flags overflow, underflow and zero. Start/done handshake mirrors the mantissa ALU so the two chain directly.

Parameters:
- EXP_W, 8, biased exponent width
- FRAC_W, 23, stored fraction width
- MANT_W, 26, input mantissa width: hidden bit [25], fraction [24:2], guard [1], sticky [0]

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  sampled at posedge while IDLE; loads all inputs
- sign_in  in  1  result sign
- exp_in  in  EXP_W  biased exponent, referenced to hidden-bit position [25]
- carry_in  in  1  mantissa ALU carry, weight 2^26
- mant_in  in  MANT_W  mantissa ALU result
- busy  out  1  high from the load edge until done
- done  out  1  one-cycle pulse; result and flags valid from this cycle
- result  out  32  packed {sign, exp[7:0], frac[22:0]}; held until next load
- overflow  out  1  result forced to ±infinity
- underflow  out  1  result flushed to ±0 by exponent exhaustion
- zero  out  1  input mantissa and carry were both zero

Behaviour:
- Reset, asynchronous: state IDLE; busy, done, overflow, underflow, zero = 0; result = 0; internal registers = 0. Reset mid-operation aborts with no done pulse.
- Internal working registers: 27-bit mantissa m = {carry_in, mant_in} and 10-bit signed exponent e, so over- and underflow are detectable.
- IDLE: on start, load m, e and sign; clear all flags; busy=1; go to NORM.
- start is ignored while busy=1.
- NORM, evaluated each cycle:
  - m == 0: zero=1, go to PACK with signed-zero result.
  - m[26] set: right shift by 1, new m[0] = old m[1] | old m[0] (sticky); e += 1; go to ROUND.
  - m[25] set: go to ROUND with no shift.
  - Otherwise: left shift by 1, zero-filled; e -= 1. If the new e <= 0, set underflow=1 and go to PACK with ±0.
- ROUND, round-to-nearest-even:
  - inc = g & (s | lsb), where g = m[1], s = m[0], lsb = m[2].
  - m[26:2] += inc.
  - If this carries into m[26]: shift right by 1 and set e += 1.
  - If e >= 255: overflow=1, result = ±infinity. Go to PACK.
- PACK: register result = {sign, e[7:0], m[24:2]}, or the forced ±0 / ±inf. Assert done for 1 cycle; busy=0; go to IDLE.
- Latency with start sampled at edge E0:
  - Already-normalized input or carry case: done is high after edge E3.
  - Input needing k left shifts: done is high after edge E3+k, with k at most 25.
  - Zero input: done is high after edge E2.
- Flags and result persist after done until the next load or reset.
- When start and reset coincide, reset wins.

Decomposition:
- Shared package float_pkg holds:
  - EXP_W, FRAC_W, MANT_W
  - BIAS = 127 and EXP_MAX = 255
  - state encoding: IDLE, NORM, ROUND, PACK
  - constants for ±infinity and ±0 patterns
- Sub-module float_round (combinational RNE increment plus renormalize-on-carry) is natural, so an adder/subtractor normalizer can reuse it.

Test Plan:
- Normalized input: mant_in=26'h2000000, carry=0, exp=127, sign=0 -> result=32'h3F800000; done exactly 3 cycles after the start edge; all flags 0.
- Carry case: carry=1, mant=0, exp=127 -> result=32'h40000000 with latency 3. Also exp=254, carry=1, sign=1 -> result=32'hFF800000, overflow=1.
- Left normalize: mant=26'h0000004, exp=150 -> 23 shifts, result=32'h3F800000; done 26 cycles after start; busy high throughout; start pulsed mid-run is ignored.
- RNE ties:
  - mant=26'h2000002 (tie, even lsb) -> 32'h3F800000.
  - mant=26'h2000006 (tie, odd lsb) -> 32'h3F800002.
  - mant=26'h3FFFFFE, exp=127 -> rounds up into carry, renormalizes to 32'h40000000.
- Zero/underflow:
  - mant=0, carry=0, sign=1 -> result=32'h80000000, zero=1, latency 2.
  - mant=26'h0000001, exp=5 -> result=0, underflow=1.
- Reset mid-NORM, during a 20-shift run -> busy=0, done never pulses, result=0. A following start completes normally.
